umul_bi_seq: RTL and testbench
==============================

Name: umul_bi_seq

Overview:
- Sequencer for one bipolar unary multiplier (the uMUL_bi datapath).
- Accepts a start request with a binary operand B.
- Drives the multiplier's load, clear and enable controls for one load cycle, then for a 2^LOGLEN-cycle stream window.
- Counts the ones on the multiplier's product bit-stream and returns the count as a registered binary result with a done pulse.

Parameters:
- BITWIDTH, 8, width of operand B and of the multiplier's RNG comparison.
- LOGLEN, 8, log2 of the stream window length (window = 2^LOGLEN cycles). Must be >= 1.

Ports:
- iClk  in  1  clock.
- iRstN  in  1  asynchronous active-low reset.
- iStart  in  1  start request; sampled only in IDLE.
- iB  in  BITWIDTH  operand B; captured on an accepted start.
- iMult  in  1  product bit from the multiplier (oMult), valid in the same cycle.
- oB  out  BITWIDTH  captured operand, to the multiplier's iB.
- oLoadB  out  1  multiplier operand-load strobe.
- oClr  out  1  multiplier RNG clear strobe.
- oEn  out  1  multiplier enable.
- oBusy  out  1  high from LOAD through the end of RUN.
- oDone  out  1  one-cycle pulse when the result is updated.
- oResult  out  LOGLEN+1  count of ones seen in the last window.

Behaviour:
- Reset: the clock is iClk; reset is asynchronous and active-low on iRstN. Reset is asynchronous assertion and forces:
  - state = IDLE;
  - oB, oResult and the internal counters = 0;
  - oLoadB, oClr, oEn, oBusy, oDone = 0.
- States: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from state only; no output depends combinationally on any input.
- IDLE:
  - All strobes are 0.
  - iStart=1 → capture iB into oB and go to LOAD.
  - iStart=0 → stay in IDLE.
- LOAD (exactly 1 cycle):
  - oLoadB=1, oClr=1, oEn=1, oBusy=1. The multiplier latches oB and clears its RNGs.
  - The ones counter and the window counter clear to 0.
  - Next state is RUN.
- RUN (exactly 2^LOGLEN cycles):
  - oEn=1, oBusy=1, oLoadB=0, oClr=0.
  - Each cycle, the ones counter increments when iMult=1.
  - The window counter (LOGLEN bits) increments every cycle.
  - On the cycle where the window counter equals 2^LOGLEN-1, that cycle's iMult is still counted and the next state is DONE.
- DONE (exactly 1 cycle):
  - oResult loads the ones counter and oDone=1.
  - oEn=0, oBusy=0.
  - Next state is IDLE.
- Latency: iStart accepted in cycle 0 → LOAD in cycle 1 → RUN in cycles 2..2^LOGLEN+1 → oDone=1 and new oResult visible in cycle 2^LOGLEN+2.
- Back-to-back: iStart=1 in the DONE cycle is ignored. A new operation may be accepted on the first IDLE cycle after DONE.
- iStart and iB are ignored in LOAD, RUN and DONE. oB stays stable for the whole operation.
- oResult holds its value until the next DONE.
- Counter widths:
  - The ones counter is LOGLEN+1 bits, so the all-ones window gives 2^LOGLEN with no overflow.
  - The window counter wraps naturally; it is reset to 0 in LOAD, so a wrap is never observed.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no oDone pulse, partial count discarded.

Optional Feature:
- Macro: UMUL_BI_SEQ_SIGNED_EN.
- When defined:
  - Adds output oSigned, width LOGLEN+2, two's complement, value 2*count - 2^LOGLEN. This is the bipolar value scaled by 2^LOGLEN, range -2^LOGLEN..+2^LOGLEN.
  - oSigned is registered and updated in the same DONE cycle as oResult.
  - oSigned resets to 0 and holds between operations.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then iStart=1 with iB=8'h80 and iMult forced to 1 (LOGLEN=8):
  - oLoadB and oClr high for exactly cycle 1;
  - oEn high for cycles 1..257;
  - oDone only in cycle 258, with oResult=256.
- iMult forced to 0 → oResult=0. With the signed macro defined, oSigned=-256.
- iMult toggling 1,0,1,0,... during RUN → oResult=128. With the signed macro defined, oSigned=0.
- iStart pulsed at cycles 50 and 258 (mid-RUN and in DONE):
  - both are ignored, and oB is unchanged;
  - the next start is accepted only from cycle 259 on.
- iRstN dropped low at cycle 100 of RUN:
  - all outputs are 0 asynchronously, with no oDone;
  - a fresh start afterwards gives the full correct count for the new window.
- Two consecutive operations (iMult=1 in 64 cycles, then iMult=1 in 192 cycles) → oResult=64, then 192.
  - With the signed macro defined, oSigned=-128, then +128.
  - oResult holds 64 through the whole second RUN.

Source files
------------

// File: rtl/umul_bi_seq_if.sv
// umul_bi_seq_if: start/result handshake and multiplier control bundle for umul_bi_seq
//   iStart, iB    start request and operand B (driven by the requester)
//   iMult         product bit from the multiplier
//   oB            captured operand to the multiplier
//   oLoadB, oClr  multiplier operand-load and RNG-clear strobes
//   oEn           multiplier enable
//   oBusy, oDone  status: busy through LOAD/RUN, one-cycle done pulse
//   oResult       ones count of the last window
//   oSigned       bipolar value scaled by 2^LOGLEN (only with UMUL_BI_SEQ_SIGNED_EN)
interface umul_bi_seq_if #(
  parameter int BITWIDTH = 8,
  parameter int LOGLEN   = 8
);
  logic                 iStart;
  logic [BITWIDTH-1:0]  iB;
  logic                 iMult;
  logic [BITWIDTH-1:0]  oB;
  logic                 oLoadB;
  logic                 oClr;
  logic                 oEn;
  logic                 oBusy;
  logic                 oDone;
  logic [LOGLEN:0]      oResult;
`ifdef UMUL_BI_SEQ_SIGNED_EN
  logic signed [LOGLEN+1:0] oSigned;
  modport slave (input iStart, iB, iMult, output oB, oLoadB, oClr, oEn, oBusy, oDone, oResult, oSigned);
  modport master (output iStart, iB, iMult, input oB, oLoadB, oClr, oEn, oBusy, oDone, oResult, oSigned);
`else
  modport slave (input iStart, iB, iMult, output oB, oLoadB, oClr, oEn, oBusy, oDone, oResult);
  modport master (output iStart, iB, iMult, input oB, oLoadB, oClr, oEn, oBusy, oDone, oResult);
`endif
endinterface

// File: rtl/umul_bi_seq.sv
// umul_bi_seq: sequencer for a bipolar unary multiplier; loads B, runs a 2^LOGLEN window, counts product ones
//   iClk   clock
//   iRstN  asynchronous active-low reset
//   bus    umul_bi_seq_if slave: start/operand in, multiplier strobes out, result/done out
//   Optional macro UMUL_BI_SEQ_SIGNED_EN adds bus.oSigned = 2*count - 2^LOGLEN.
module umul_bi_seq #(
  parameter int BITWIDTH = 8,
  parameter int LOGLEN   = 8
) (
  input  logic          iClk,
  input  logic          iRstN,
  umul_bi_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] b_q, b_d;
  logic [LOGLEN:0]     ones_q, ones_d;
  logic [LOGLEN-1:0]   win_q, win_d;
  logic [LOGLEN:0]     result_q, result_d;
`ifdef UMUL_BI_SEQ_SIGNED_EN
  logic signed [LOGLEN+1:0] signed_q, signed_d;
`endif
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= IDLE;
      b_q      <= '0;
      ones_q   <= '0;
      win_q    <= '0;
      result_q <= '0;
`ifdef UMUL_BI_SEQ_SIGNED_EN
      signed_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      ones_q   <= ones_d;
      win_q    <= win_d;
      result_q <= result_d;
`ifdef UMUL_BI_SEQ_SIGNED_EN
      signed_q <= signed_d;
`endif
    end
  end
  // The last RUN cycle's product bit is folded in as the result is captured,
  // so the new result is already visible during DONE.
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    ones_d   = ones_q;
    win_d    = win_q;
    result_d = result_q;
`ifdef UMUL_BI_SEQ_SIGNED_EN
    signed_d = signed_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = bus.iStart ? LOAD : IDLE;
        b_d     = bus.iStart ? bus.iB : b_q;
      end
      LOAD: begin
        ones_d  = '0;
        win_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        ones_d = ones_q + (LOGLEN+1)'(bus.iMult);
        win_d  = win_q + LOGLEN'(1);
        if (&win_q) begin
          state_d  = DONE;
          result_d = ones_d;
`ifdef UMUL_BI_SEQ_SIGNED_EN
          signed_d = {ones_d, 1'b0} - (LOGLEN+2)'(2**LOGLEN);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.oB      = b_q;
  assign bus.oLoadB  = state_q == LOAD;
  assign bus.oClr    = state_q == LOAD;
  assign bus.oEn     = state_q == LOAD || state_q == RUN;
  assign bus.oBusy   = state_q == LOAD || state_q == RUN;
  assign bus.oDone   = state_q == DONE;
  assign bus.oResult = result_q;
`ifdef UMUL_BI_SEQ_SIGNED_EN
  assign bus.oSigned = signed_q;
`endif
endmodule

// File: tb/tb_umul_bi_seq.sv
// tb_umul_bi_seq: directed scoreboard bench for umul_bi_seq (LOGLEN=8, BITWIDTH=8)
module tb_umul_bi_seq;
  logic iClk, iRstN;
  int   n_cmp = 0;
  int   n_err = 0;
  int   prev_res = 0;
  typedef struct { int res; int sgn; } exp_t;
  exp_t exp_q[$];
  umul_bi_seq_if #(.BITWIDTH(8), .LOGLEN(8)) bus ();
  umul_bi_seq #(.BITWIDTH(8), .LOGLEN(8)) dut (.iClk(iClk), .iRstN(iRstN), .bus(bus));
  initial begin
    iClk = 0;
    forever #5 iClk = ~iClk;
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_oB"}, bus.oB, 0);
    chk({tag, "_oLoadB"}, bus.oLoadB, 0);
    chk({tag, "_oClr"}, bus.oClr, 0);
    chk({tag, "_oEn"}, bus.oEn, 0);
    chk({tag, "_oBusy"}, bus.oBusy, 0);
    chk({tag, "_oDone"}, bus.oDone, 0);
    chk({tag, "_oResult"}, bus.oResult, 0);
`ifdef UMUL_BI_SEQ_SIGNED_EN
    chk({tag, "_oSigned"}, $signed(bus.oSigned), 0);
`endif
  endtask
  // Scoreboard monitor: every done pulse consumes one expected result.
  always @(negedge iClk) begin
    if (iRstN && bus.oDone) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("oResult", bus.oResult, e.res);
`ifdef UMUL_BI_SEQ_SIGNED_EN
        chk("oSigned", $signed(bus.oSigned), e.sgn);
`endif
      end
    end
  end
  function automatic logic mult_bit(input int mode, input int n, input int k);
    return mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : mode == 2 ? (k % 2 == 0) : (k < n);
  endfunction
  // Cycle 0 = start accepted; LOAD = 1; RUN = 2..257; DONE = 258; idle at 259.
  task automatic do_op(input logic [7:0] b, input int mode, input int n, input int exp_res,
                       input int exp_sgn, input bit pulses);
    exp_q.push_back('{exp_res, exp_sgn});
    bus.iStart = 1;
    bus.iB     = b;
    bus.iMult  = 0;
    @(posedge iClk); #1;
    for (int c = 1; c <= 258; c++) begin
      bus.iStart = pulses && (c == 50 || c == 258);
      if (pulses) bus.iB = 8'h3C;
      bus.iMult  = (c >= 2 && c <= 257) ? mult_bit(mode, n, c - 2) : 1'b0;
      @(negedge iClk);
      chk("oLoadB", bus.oLoadB, c == 1);
      chk("oClr", bus.oClr, c == 1);
      chk("oEn", bus.oEn, c <= 257);
      chk("oBusy", bus.oBusy, c <= 257);
      chk("oDone_timing", bus.oDone, c == 258);
      chk("oB_stable", bus.oB, b);
      if (c < 258) chk("oResult_hold", bus.oResult, prev_res);
      @(posedge iClk); #1;
    end
    bus.iStart = 0;
    bus.iMult  = 0;
    prev_res   = exp_res;
    @(negedge iClk);
    chk("idle_after_done", bus.oBusy, 0);
    chk("idle_result_hold", bus.oResult, exp_res);
    @(posedge iClk); #1;
  endtask
  task automatic abort_op();
    bus.iStart = 1;
    bus.iB     = 8'hC3;
    @(posedge iClk); #1;
    bus.iStart = 0;
    for (int c = 1; c <= 102; c++) begin
      bus.iMult = c >= 2;
      if (c < 102) begin
        @(posedge iClk); #1;
      end
    end
    #2 iRstN = 0;
    #1 chk_all_zero("async_rst");
    repeat (2) @(negedge iClk);
    chk_all_zero("held_rst");
    iRstN     = 1;
    bus.iMult = 0;
    prev_res  = 0;
    @(posedge iClk); #1;
  endtask
  initial begin
    iRstN      = 0;
    bus.iStart = 0;
    bus.iB     = 0;
    bus.iMult  = 0;
    #2 chk_all_zero("reset");
    #10 iRstN = 1;
    @(posedge iClk); #1;
    do_op(8'h80, 0, 0, 256, 256, 0);
    do_op(8'h80, 1, 0, 0, -256, 0);
    do_op(8'hA5, 2, 0, 128, 0, 1);
    abort_op();
    do_op(8'h5A, 0, 0, 256, 256, 0);
    do_op(8'h40, 3, 64, 64, -128, 0);
    do_op(8'hC0, 3, 192, 192, 128, 0);
    repeat (3) @(posedge iClk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
